// File: rtl/marker_corner_finder_if.sv
// Pixel stream into the corner finder and the corner results it publishes.
interface marker_corner_finder_if;
    logic        i_frame_start;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_addr_valid;
    logic        o_lost;
    logic [19:0] o_ul_addr;
    logic [19:0] o_ur_addr;
    logic [19:0] o_dl_addr;
    logic [19:0] o_dr_addr;
    logic [19:0] o_pixel_count;

    // Camera side: drives pixels, observes results
    modport master (
        output i_frame_start, i_valid, i_data,
        input  o_addr_valid, o_lost, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr, o_pixel_count
    );

    // Corner finder side
    modport slave (
        input  i_frame_start, i_valid, i_data,
        output o_addr_valid, o_lost, o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr, o_pixel_count
    );
endinterface

// File: rtl/marker_corner_finder.sv
// Marker corner finder: thresholds each pixel of a frame, tracks the four
// extreme marker points and publishes them (or a lost flag) at end of frame.
module marker_corner_finder #(
    parameter int          WIDTH     = 800,
    parameter int          HEIGHT    = 600,
    parameter logic [9:0]  R_MIN     = 10'd600,
    parameter logic [9:0]  GB_MAX    = 10'd300,
    parameter int          MIN_COUNT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    marker_corner_finder_if.slave  bus
);

    localparam logic [9:0]  COL_LAST  = 10'(WIDTH - 1);
    localparam logic [9:0]  ROW_LAST  = 10'(HEIGHT - 1);
    localparam logic [19:0] CNT_MIN   = 20'(MIN_COUNT);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  col_q, row_q;
    logic [9:0]  cur_col, cur_row;
    logic        frame_req, start, abort, accept, last, publish;

    logic [9:0]  pix_r, pix_g, pix_b;
    logic        is_marker;
    logic        unused_pad;

    logic        s1_valid, s1_mk;
    logic [9:0]  s1_row, s1_col;
    logic [10:0] s1_s, s1_d;

    logic [19:0] acc_cnt;
    logic [19:0] ul_q, ur_q, dl_q, dr_q;
    logic [10:0] ul_s, dr_s, ur_d, dl_d;
    logic        count_ok;

    assign pix_r      = bus.i_data[29:20];
    assign pix_g      = bus.i_data[19:10];
    assign pix_b      = bus.i_data[9:0];
    assign unused_pad = ^bus.i_data[31:30];
    assign is_marker  = (pix_r >= R_MIN) && (pix_g <= GB_MAX) && (pix_b <= GB_MAX);
    assign count_ok   = (acc_cnt >= CNT_MIN);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = last ? DRAIN : SCAN;
            end
            SCAN: begin
                if (abort)     state_d = IDLE;
                else if (last) state_d = DRAIN;
            end
            DRAIN: begin
                if (publish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control decode: pixel acceptance, frame start/abort, end of frame, publish.
    // Publish waits in DRAIN until the last pixel has left stage 1, so the
    // accumulators already include it when the outputs are loaded.
    always_comb begin
        frame_req = bus.i_valid && bus.i_frame_start && (state_q != DRAIN);
        start     = frame_req && i_enable;
        abort     = frame_req && !i_enable && (state_q == SCAN);
        accept    = start || ((state_q == SCAN) && bus.i_valid && !frame_req);
        cur_col   = start ? '0 : col_q;
        cur_row   = start ? '0 : row_q;
        last      = accept && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        publish   = (state_q == DRAIN) && !s1_valid;
    end

    // Raster position counters, advanced per accepted pixel
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col_q <= '0;
                row_q <= cur_row + 10'd1;
            end else begin
                col_q <= cur_col + 10'd1;
                row_q <= cur_row;
            end
        end
    end

    // Stage 1: classify pixel and form the diagonal keys
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_mk    <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_s     <= '0;
            s1_d     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_mk  <= is_marker;
                s1_row <= cur_row;
                s1_col <= cur_col;
                s1_s   <= {1'b0, cur_row} + {1'b0, cur_col};
                s1_d   <= {1'b0, cur_col} + 11'd1023 - {1'b0, cur_row};
            end
        end
    end

    // Stage 2: extreme-point accumulators; a frame start clears them and
    // overrides any in-flight pixel from the abandoned frame
    always_ff @(posedge i_clk) begin
        if (i_rst || start) begin
            acc_cnt <= '0;
            ul_q    <= '0;
            ur_q    <= '0;
            dl_q    <= '0;
            dr_q    <= '0;
            ul_s    <= '0;
            dr_s    <= '0;
            ur_d    <= '0;
            dl_d    <= '0;
        end else if (s1_valid && s1_mk) begin
            if (acc_cnt != '1) acc_cnt <= acc_cnt + 20'd1;
            if (acc_cnt == '0) begin
                ul_q <= {s1_row, s1_col};
                ur_q <= {s1_row, s1_col};
                dl_q <= {s1_row, s1_col};
                dr_q <= {s1_row, s1_col};
                ul_s <= s1_s;
                dr_s <= s1_s;
                ur_d <= s1_d;
                dl_d <= s1_d;
            end else begin
                if (s1_s < ul_s) begin
                    ul_q <= {s1_row, s1_col};
                    ul_s <= s1_s;
                end
                if (s1_s > dr_s) begin
                    dr_q <= {s1_row, s1_col};
                    dr_s <= s1_s;
                end
                if (s1_d > ur_d) begin
                    ur_q <= {s1_row, s1_col};
                    ur_d <= s1_d;
                end
                if (s1_d < dl_d) begin
                    dl_q <= {s1_row, s1_col};
                    dl_d <= s1_d;
                end
            end
        end
    end

    // Output registers: one-cycle pulses, corners held between valid publishes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_addr_valid  <= 1'b0;
            bus.o_lost        <= 1'b0;
            bus.o_pixel_count <= '0;
            bus.o_ul_addr     <= '0;
            bus.o_ur_addr     <= '0;
            bus.o_dl_addr     <= '0;
            bus.o_dr_addr     <= '0;
        end else begin
            bus.o_addr_valid <= publish && count_ok;
            bus.o_lost       <= publish && !count_ok;
            if (publish) bus.o_pixel_count <= acc_cnt;
            if (publish && count_ok) begin
                bus.o_ul_addr <= ul_q;
                bus.o_ur_addr <= ur_q;
                bus.o_dl_addr <= dl_q;
                bus.o_dr_addr <= dr_q;
            end
        end
    end

endmodule

// File: tb/tb_marker_corner_finder.sv
// Randomized self-checking bench for marker_corner_finder on an 8x4 frame.
module tb_marker_corner_finder;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int N    = W * H;
    localparam int MINC = 1;

    logic clk = 1'b0;
    logic rst;
    logic en;

    marker_corner_finder_if bus();

    marker_corner_finder #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .R_MIN     (10'd600),
        .GB_MAX    (10'd300),
        .MIN_COUNT (MINC)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_enable (en),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge
    int av_n = 0, lost_n = 0, pulse_cyc = 0, both_n = 0;
    always @(negedge clk) begin
        if (bus.o_addr_valid) begin av_n++; pulse_cyc = cyc; end
        if (bus.o_lost)       begin lost_n++; pulse_cyc = cyc; end
        if (bus.o_addr_valid && bus.o_lost) both_n++;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame contents and expected published state
    bit          mk [N];
    logic [31:0] pix[N];
    logic [19:0] exp_ul = '0, exp_ur = '0, exp_dl = '0, exp_dr = '0, exp_pc = '0;
    bit          exp_ok;
    int          last_edge;

    function automatic logic [31:0] make_pix(input bit marker);
        logic [9:0] r, g, b;
        int k;
        if (marker) begin
            k = $urandom_range(0, 3);
            r = (k == 0) ? 10'd600 : 10'($urandom_range(600, 1023));
            g = (k == 1) ? 10'd300 : 10'($urandom_range(0, 300));
            b = (k == 2) ? 10'd300 : 10'($urandom_range(0, 300));
        end else begin
            k = $urandom_range(0, 4);
            r = 10'($urandom_range(600, 1023));
            g = 10'($urandom_range(0, 300));
            b = 10'($urandom_range(0, 300));
            case (k)
                0: begin r = '0; g = '0; b = '0; end
                1: r = 10'($urandom_range(0, 599));
                2: begin r = 10'd599; g = '0; b = '0; end
                3: g = 10'($urandom_range(301, 1023));
                default: b = 10'($urandom_range(301, 1023));
            endcase
        end
        return {2'b00, r, g, b};
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin mk[i] = 1'b0; pix[i] = '0; end
    endtask

    task automatic put(input int r, input int c);
        mk[r*W + c]  = 1'b1;
        pix[r*W + c] = {2'b00, 10'd1023, 10'd0, 10'd0};
    endtask

    // Score for corner kind: ul=min(r+c), ur=max(c-r), dl=min(c-r), dr=max(r+c)
    function automatic int score(input int kind, input int idx);
        int r, c;
        r = idx / W;
        c = idx % W;
        case (kind)
            0: return -(r + c);
            1: return c - r;
            2: return r - c;
            default: return r + c;
        endcase
    endfunction

    // Best score over all markers, then the first raster pixel reaching it
    function automatic logic [19:0] corner(input int kind);
        int best, idx;
        bit found;
        found = 1'b0; best = 0; idx = 0;
        for (int i = 0; i < N; i++)
            if (mk[i] && (!found || score(kind, i) > best)) begin
                best = score(kind, i);
                found = 1'b1;
            end
        for (int i = N - 1; i >= 0; i--)
            if (mk[i] && score(kind, i) == best) idx = i;
        return {10'(idx / W), 10'(idx % W)};
    endfunction

    task automatic model_frame();
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) if (mk[i]) cnt++;
        exp_pc = 20'(cnt);
        exp_ok = (cnt >= MINC);
        if (exp_ok) begin
            exp_ul = corner(0);
            exp_ur = corner(1);
            exp_dl = corner(2);
            exp_dr = corner(3);
        end
    endtask

    // Send pix[0..n-1] with frame_start on the first; optional gaps and trailing extras
    task automatic send_range(input int n, input bit gaps, input int extra);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) begin
                    bus.i_valid = 1'b0;
                    bus.i_frame_start = 1'b0;
                    bus.i_data = $urandom;
                    @(posedge clk); #1;
                end
            bus.i_valid = 1'b1;
            bus.i_frame_start = (i == 0);
            bus.i_data = pix[i];
            @(posedge clk); #1;
            last_edge = cyc;
        end
        for (int i = 0; i < extra; i++) begin
            bus.i_valid = 1'b1;
            bus.i_frame_start = 1'b0;
            bus.i_data = {2'b00, 10'd1023, 10'd0, 10'd0};
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        bus.i_frame_start = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ul"}, 32'(bus.o_ul_addr), 32'(exp_ul));
        chk({tag, ".ur"}, 32'(bus.o_ur_addr), 32'(exp_ur));
        chk({tag, ".dl"}, 32'(bus.o_dl_addr), 32'(exp_dl));
        chk({tag, ".dr"}, 32'(bus.o_dr_addr), 32'(exp_dr));
        chk({tag, ".cnt"}, 32'(bus.o_pixel_count), 32'(exp_pc));
    endtask

    // Wait a fixed budget after the frame, then check pulses, latency and outputs
    task automatic expect_result(input string tag, input bit want_pulse);
        repeat (8) @(posedge clk);
        #1;
        if (want_pulse) begin
            chk({tag, ".av_pulses"}, 32'(av_n), exp_ok ? 32'd1 : 32'd0);
            chk({tag, ".lost_pulses"}, 32'(lost_n), exp_ok ? 32'd0 : 32'd1);
            chk({tag, ".latency"}, 32'(pulse_cyc - last_edge), 32'd2);
        end else begin
            chk({tag, ".av_pulses"}, 32'(av_n), 32'd0);
            chk({tag, ".lost_pulses"}, 32'(lost_n), 32'd0);
        end
        check_outputs(tag);
        av_n = 0;
        lost_n = 0;
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_frame_start = 1'b0;
        bus.i_data = '0;
        en  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.av", 32'(bus.o_addr_valid), 32'd0);
        chk("reset.lost", 32'(bus.o_lost), 32'd0);
        check_outputs("reset");

        // Single marker at (2,5)
        clear_frame(); put(2, 5); model_frame();
        send_range(N, 1'b0, 0);
        expect_result("single", 1'b1);

        // Four markers at the rectangle corners
        clear_frame(); put(1, 1); put(1, 6); put(3, 1); put(3, 6); model_frame();
        send_range(N, 1'b0, 0);
        expect_result("four", 1'b1);

        // All-black frame: lost, corners hold
        clear_frame(); model_frame();
        send_range(N, 1'b0, 0);
        expect_result("black", 1'b1);

        // Two markers with random valid gaps
        clear_frame(); put(1, 1); put(3, 6); model_frame();
        send_range(N, 1'b1, 0);
        expect_result("gaps", 1'b1);

        // Restart at (2,3): partial frame has markers, new frame only (0,7)
        clear_frame(); put(0, 2); put(1, 4); put(2, 1);
        send_range(19, 1'b0, 0);
        clear_frame(); put(0, 7); model_frame();
        send_range(N, 1'b0, 0);
        expect_result("restart", 1'b1);

        // Reset mid-scan, then a full frame
        clear_frame(); put(0, 3); put(1, 0);
        send_range(10, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ul = '0; exp_ur = '0; exp_dl = '0; exp_dr = '0; exp_pc = '0;
        expect_result("midrst", 1'b0);
        clear_frame(); put(2, 2); put(3, 7); put(0, 4); model_frame();
        send_range(N, 1'b0, 0);
        expect_result("after_rst", 1'b1);

        // Disabled at frame start: ignored entirely
        en = 1'b0;
        clear_frame(); put(1, 2); put(2, 6);
        send_range(N, 1'b0, 0);
        expect_result("disabled", 1'b0);
        en = 1'b1;

        // Randomized frames: density, colours near thresholds, gaps, trailing extras
        for (int f = 0; f < 25; f++) begin
            int dens;
            dens = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) begin
                case (dens)
                    0: mk[i] = 1'b0;
                    1: mk[i] = ($urandom_range(0, 49) == 0);
                    2: mk[i] = ($urandom_range(0, 9) == 0);
                    default: mk[i] = ($urandom_range(0, 9) < 4);
                endcase
                pix[i] = make_pix(mk[i]);
            end
            model_frame();
            send_range(N, 1'(($urandom_range(0, 1))), $urandom_range(0, 3));
            expect_result($sformatf("rand%0d", f), 1'b1);
        end

        chk("never_both", 32'(both_n), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/marker_corner_finder.md
Name: marker_corner_finder

Overview:
- Sits directly upstream of the image generator and feeds its four corner addresses plus the address-valid strobe.
- Scans the camera pixel stream of each frame and classifies every pixel as marker or background by a colour threshold.
- Tracks the four extreme marker points (upper-left, upper-right, down-left, down-right).
- At end of frame, publishes them as packed {row[9:0], col[9:0]} addresses with a one-cycle valid pulse, or flags the frame as lost.

Parameters:
- WIDTH, 800: active pixels per row.
- HEIGHT, 600: active rows per frame.
- R_MIN, 10'd600: minimum 10-bit red for a marker pixel.
- GB_MAX, 10'd300: maximum 10-bit green and blue for a marker pixel.
- MIN_COUNT, 16: minimum marker pixels per frame for a valid result.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_enable  in  1  scanning allowed; sampled only at frame start.
- i_frame_start  in  1  marks that the pixel presented with i_valid is (row 0, col 0).
- i_valid  in  1  pixel strobe.
- i_data  in  32  pixel {2'b0, R[9:0], G[9:0], B[9:0]}.
- o_addr_valid  out  1  one-cycle pulse: corner outputs updated.
- o_lost  out  1  one-cycle pulse: frame ended with fewer than MIN_COUNT marker pixels.
- o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr  out  20 each  {row[19:10], col[9:0]}.
- o_pixel_count  out  20  marker pixel count of the last completed frame.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulators cleared.
- A synchronous reset mid-scan aborts the frame; no pulse is produced for it.
- States:
  - IDLE -> SCAN on (i_valid & i_frame_start & i_enable). That pixel is (0,0).
  - SCAN -> DRAIN after accepting pixel (HEIGHT-1, WIDTH-1).
  - DRAIN -> IDLE after publishing.
- Counters:
  - col/row are internal 10-bit counters, advanced only on i_valid in SCAN.
  - col wraps at WIDTH-1 to 0 and increments row.
  - Gaps in i_valid stall the counters with no effect.
- Restart: i_frame_start with i_valid while in SCAN discards the accumulators and restarts at (0,0) (re-check i_enable). No pulse is produced for the partial frame.
- Ignored input: pixels received in IDLE or DRAIN are ignored; this includes extra pixels beyond WIDTH*HEIGHT.
- Stage 1 (registered):
  - mk = (R >= R_MIN) & (G <= GB_MAX) & (B <= GB_MAX).
  - s = row + col (11-bit unsigned).
  - d = col + 1023 - row (11-bit unsigned, encodes col-row).
  - Row, col and valid are carried alongside.
- Stage 2 (accumulate, when stage-1 valid & mk):
  - ul <- point with minimum s.
  - dr <- point with maximum s.
  - ur <- point with maximum d.
  - dl <- point with minimum d.
  - Strict comparisons: ties keep the earliest pixel in raster order.
  - The first marker pixel of a frame initialises all four corners.
  - count increments and saturates at 2^20-1.
- Publish:
  - Let edge E0 sample the last pixel; E1 updates the accumulators; E2 registers the outputs.
  - o_addr_valid or o_lost is high in the cycle after E2, for exactly one cycle.
- Publish outcomes:
  - count >= MIN_COUNT: load the four corner outputs and o_pixel_count, and pulse o_addr_valid.
  - Otherwise: pulse o_lost, load o_pixel_count only, and hold the corner outputs at their previous values.
- Hold rule: corner outputs are stable between pulses, since the downstream stage reads them continuously.
- Accumulators clear on every accepted frame start.
- o_addr_valid and o_lost are never high together.

Test Plan:
- WIDTH=8, HEIGHT=4, MIN_COUNT=1; one marker pixel (R=1023, G=B=0) at row 2, col 5; all others black -> single o_addr_valid pulse 3 cycles after the last pixel; all four addrs = {10'd2, 10'd5}; o_pixel_count=1.
- Same config; markers at (1,1), (1,6), (3,1), (3,6) -> ul={1,1}, ur={1,6}, dl={3,1}, dr={3,6}; count=4.
- All-black frame after the previous test -> o_lost pulse; o_addr_valid stays 0; corners still hold the previous values; o_pixel_count=0.
- Random i_valid gaps (50% duty) on the two-marker frame (1,1), (3,6) -> same result as gap-free; pulse follows the last valid pixel by 3 cycles.
- i_frame_start reasserted at pixel (2,3) with markers only before it; new frame has a marker at (0,7) -> exactly one pulse, for the new frame; all addrs = {0,7}.
- i_rst high for one cycle mid-SCAN, then a full frame -> outputs read 0 after reset; no pulse for the aborted frame; the next frame publishes normally.
- i_enable=0 at frame start -> no pulses, outputs unchanged.
